cve2_wb_stage: RTL
==================

// Module: cve2_wb_stage
// PURPOSE
//  Optional registered writeback stage between ID/EX and the register file.
//  It generalises the plain passthrough writeback to a one-entry pipeline slot.
//  The slot holds an instruction until its result or its LSU response is
//  available, and it drives forwarding/hazard info, retire strobes and a
//  retire counter. With WritebackStage=0 it reduces to a combinational
//  passthrough.
// PARAMETERS
//  WritebackStage  1   1: registered one-entry stage; 0: combinational passthrough
//  DataWidth       32  RF write data width
//  RetCntWidth     16  width of retire counter instr_ret_cnt_o (wraps)
// PORTS
//  clk_i                          in   1   clock
//  rst_ni                         in   1   synchronous reset, active low
//  en_wb_i                        in   1   ID/EX hands an instruction to WB this cycle
//  instr_type_wb_i                in   2   0 ALU/other, 1 load, 2 store (3 = illegal)
//  instr_is_compressed_id_i       in   1   instruction is RVC
//  instr_perf_count_id_i          in   1   instruction counts toward retire stats
//  ready_wb_o                     out  1   WB can accept an instruction this cycle
//  rf_waddr_id_i                  in   5   destination register
//  rf_wdata_id_i                  in   DW  non-load result
//  rf_we_id_i                     in   1   non-load RF write enable
//  rf_wdata_lsu_i                 in   DW  load data
//  rf_we_lsu_i                    in   1   load RF write enable
//  lsu_resp_valid_i               in   1   LSU response this cycle
//  lsu_resp_err_i                 in   1   LSU response carries bus error
//  rf_waddr_wb_o                  out  5   RF write address
//  rf_wdata_wb_o                  out  DW  RF write data
//  rf_we_wb_o                     out  1   RF write enable
//  rf_wdata_fwd_wb_o              out  DW  held ALU result for forwarding
//  rf_write_wb_o                  out  1   WB slot will/does write rf_waddr_wb_o (hazard)
//  outstanding_load_wb_o          out  1   slot holds a load awaiting response
//  outstanding_store_wb_o         out  1   slot holds a store awaiting response
//  instr_done_wb_o                out  1   slot instruction completes this cycle
//  perf_instr_ret_wb_o            out  1   retire strobe (excludes LSU errors)
//  perf_instr_ret_compressed_wb_o out  1   retire strobe, RVC only
//  instr_ret_cnt_o                out  RCW retired-instruction count
// BEHAVIOUR
//  - Registers: valid_q, type_q, waddr_q, wdata_q, we_q, rvc_q, perf_q, cnt_q.
//    All clear to 0 on a rst_ni low at a clock edge.
//  - Reset output values:
//    - ready_wb_o=1.
//    - All other outputs 0.
//    - instr_ret_cnt_o=0.
//  - Slot states:
//    - EMPTY: valid_q=0.
//    - FULL_ALU: type 0.
//    - WAIT_LSU: type 1 or 2.
//  - done = valid_q & (type_q==0 | lsu_resp_valid_i).
//  - ready_wb_o = ~valid_q | done (combinational).
//  - Accept = en_wb_i & ready_wb_o. Accept loads the slot; next state is FULL_ALU or WAIT_LSU by type.
//  - done & ~accept -> EMPTY. done & accept -> new instruction replaces the old one, no bubble.
//  - en_wb_i while ready_wb_o=0 is a protocol error; the slot is held and the input is ignored (assert).
//  - RF write path, 1-cycle latency from accept for ALU instructions:
//    - FULL_ALU: rf_we_wb_o = we_q and rf_wdata_wb_o = wdata_q, on the cycle after accept.
//    - WAIT_LSU load: rf_we_wb_o = lsu_resp_valid_i & rf_we_lsu_i & ~lsu_resp_err_i, with data rf_wdata_lsu_i.
//    - Store: never writes.
//    - rf_waddr_wb_o = waddr_q.
//    - rf_wdata_wb_o is 0 when rf_we_wb_o=0.
//  - rf_write_wb_o = valid_q & (we_q | type_q==1). rf_wdata_fwd_wb_o = wdata_q.
//  - outstanding_load_wb_o and outstanding_store_wb_o are the WAIT_LSU slot type (valid_q qualified).
//  - Retire:
//    - perf_instr_ret_wb_o = done & perf_q & ~(lsu_resp_valid_i & lsu_resp_err_i).
//    - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & rvc_q.
//    - An LSU error still completes the instruction (instr_done_wb_o=1) but gives no retire and no RF write.
//  - cnt_q increments by 1 on each perf_instr_ret_wb_o. At all-ones it wraps to 0.
//  - lsu_resp_valid_i outside WAIT_LSU is ignored (assert never).
//  - Reset mid-WAIT_LSU drops the slot. A later stale response is ignored.
//  - Source exclusivity: rf_we_id_i and rf_we_lsu_i never both apply to one write (assert onehot0).
//  - WritebackStage=0 (all combinational, no registers except cnt_q):
//    - Outputs are driven directly from the ID and LSU inputs.
//    - done = en_wb_i.
//    - ready_wb_o=1.
//    - rf_write_wb_o, outstanding_*, and rf_wdata_fwd_wb_o are tied 0.
// TESTING
//  - ALU back-to-back: en_wb_i 3 cycles, rd x5/x6/x7 = 0x11/0x22/0x33 -> one write per cycle, 1 cycle later; ready stays 1; cnt=3.
//  - Load wait: load rd x9 accepted, response after 4 cycles with data 0xDEADBEEF ->
//    - ready_wb_o=0 and outstanding_load_wb_o=1 for 4 cycles.
//    - Then a write of x9=0xDEADBEEF, a retire strobe, and ready_wb_o=1 in the same cycle.
//  - Load error: response with err=1 -> instr_done_wb_o=1, rf_we_wb_o=0, no retire, cnt unchanged.
//  - Simultaneous: load response and a new ALU en_wb_i in one cycle -> both accepted; ALU write occurs next cycle.
//  - Counter wrap (RetCntWidth=4): 17 retires -> instr_ret_cnt_o=1. RVC retires only raise the compressed strobe.
//  - Reset mid-WAIT_LSU, then a late lsu_resp_valid_i -> no RF write, no retire, ready_wb_o=1.
//  - WritebackStage=0: rf_we_id_i=1, waddr 3, data 0x5A -> same-cycle write, ready_wb_o always 1.

Source files
------------

// File: rtl/cve2_wb_stage.sv
// Writeback stage: a one-entry slot that holds an instruction until its ALU result or LSU
// response is available, or a combinational passthrough when WritebackStage is 0.
module cve2_wb_stage #(
  parameter bit          WritebackStage = 1'b1,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned RetCntWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_wb_i,
  input  logic [1:0]             instr_type_wb_i,
  input  logic                   instr_is_compressed_id_i,
  input  logic                   instr_perf_count_id_i,
  output logic                   ready_wb_o,
  input  logic [4:0]             rf_waddr_id_i,
  input  logic [DataWidth-1:0]   rf_wdata_id_i,
  input  logic                   rf_we_id_i,
  input  logic [DataWidth-1:0]   rf_wdata_lsu_i,
  input  logic                   rf_we_lsu_i,
  input  logic                   lsu_resp_valid_i,
  input  logic                   lsu_resp_err_i,
  output logic [4:0]             rf_waddr_wb_o,
  output logic [DataWidth-1:0]   rf_wdata_wb_o,
  output logic                   rf_we_wb_o,
  output logic [DataWidth-1:0]   rf_wdata_fwd_wb_o,
  output logic                   rf_write_wb_o,
  output logic                   outstanding_load_wb_o,
  output logic                   outstanding_store_wb_o,
  output logic                   instr_done_wb_o,
  output logic                   perf_instr_ret_wb_o,
  output logic                   perf_instr_ret_compressed_wb_o,
  output logic [RetCntWidth-1:0] instr_ret_cnt_o
);

  logic                   done;
  logic                   we_id_src;
  logic                   we_lsu_src;
  logic                   perf_ret;
  logic                   lsu_err_resp;
  logic [RetCntWidth-1:0] cnt_q, cnt_d;

  assign lsu_err_resp = lsu_resp_valid_i & lsu_resp_err_i;

  if (WritebackStage) begin : g_stage
    logic                 valid_q, valid_d;
    logic [1:0]           type_q, type_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 rvc_q, rvc_d;
    logic                 perf_q, perf_d;
    logic                 accept;
    logic                 slot_alu;
    logic                 slot_load;

    assign slot_alu  = valid_q & (type_q == 2'd0);
    assign slot_load = valid_q & (type_q == 2'd1);

    assign done       = valid_q & ((type_q == 2'd0) | lsu_resp_valid_i);
    assign ready_wb_o = ~valid_q | done;
    assign accept     = en_wb_i & ready_wb_o;

    always_comb begin
      valid_d = valid_q;
      type_d  = type_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rvc_d   = rvc_q;
      perf_d  = perf_q;
      // A new instruction may replace a completing one in the same cycle.
      if (accept) begin
        valid_d = 1'b1;
        type_d  = instr_type_wb_i;
        waddr_d = rf_waddr_id_i;
        wdata_d = rf_wdata_id_i;
        we_d    = rf_we_id_i;
        rvc_d   = instr_is_compressed_id_i;
        perf_d  = instr_perf_count_id_i;
      end else if (done) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        type_q  <= 2'd0;
        waddr_q <= 5'd0;
        wdata_q <= '0;
        we_q    <= 1'b0;
        rvc_q   <= 1'b0;
        perf_q  <= 1'b0;
      end else begin
        valid_q <= valid_d;
        type_q  <= type_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        rvc_q   <= rvc_d;
        perf_q  <= perf_d;
      end
    end

    assign we_id_src  = slot_alu & we_q;
    assign we_lsu_src = slot_load & lsu_resp_valid_i & rf_we_lsu_i & ~lsu_resp_err_i;

    assign rf_we_wb_o    = we_id_src | we_lsu_src;
    assign rf_wdata_wb_o = we_id_src  ? wdata_q        :
                           we_lsu_src ? rf_wdata_lsu_i : '0;
    assign rf_waddr_wb_o = waddr_q;

    assign rf_wdata_fwd_wb_o      = wdata_q;
    assign rf_write_wb_o          = valid_q & (we_q | (type_q == 2'd1));
    assign outstanding_load_wb_o  = slot_load;
    assign outstanding_store_wb_o = valid_q & (type_q == 2'd2);

    assign perf_ret                       = done & perf_q & ~lsu_err_resp;
    assign perf_instr_ret_compressed_wb_o = perf_ret & rvc_q;

    // An empty slot may see a stale response after reset; an ALU slot never should.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(slot_alu && lsu_resp_valid_i));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(accept && (instr_type_wb_i == 2'd3)));
  end else begin : g_pass
    assign done       = en_wb_i;
    assign ready_wb_o = 1'b1;

    assign we_id_src  = rf_we_id_i;
    assign we_lsu_src = lsu_resp_valid_i & rf_we_lsu_i & ~lsu_resp_err_i;

    assign rf_we_wb_o    = we_id_src | we_lsu_src;
    assign rf_wdata_wb_o = we_id_src  ? rf_wdata_id_i  :
                           we_lsu_src ? rf_wdata_lsu_i : '0;
    assign rf_waddr_wb_o = rf_waddr_id_i;

    assign rf_wdata_fwd_wb_o      = '0;
    assign rf_write_wb_o          = 1'b0;
    assign outstanding_load_wb_o  = 1'b0;
    assign outstanding_store_wb_o = 1'b0;

    assign perf_ret                       = done & instr_perf_count_id_i & ~lsu_err_resp;
    assign perf_instr_ret_compressed_wb_o = perf_ret & instr_is_compressed_id_i;
  end

  assign instr_done_wb_o     = done;
  assign perf_instr_ret_wb_o = perf_ret;

  // Free-running retire counter, wraps at all-ones.
  assign cnt_d = cnt_q + RetCntWidth'(perf_ret);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_ret_cnt_o = cnt_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(en_wb_i && !ready_wb_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0({we_id_src, we_lsu_src}));

endmodule
